param_shift_register: RTL and testbench

- Parametrised universal shift register; successor to the team's fixed 4-bit hold/load/shift-left/shift-right register.
- Generalises to WIDTH bits and adds rotate, arithmetic-shift and clear modes.
- Adds a multi-cycle shift sequencer: one start request performs N single-bit shifts, with busy/done handshake.
- Sits between a parallel data source and a serial consumer or producer. Its clock is the already-divided system clock, so the block contains no clock divider.

---
 rtl/psr_pkg.sv | 27 ++
 rtl/psr_next_value.sv | 30 +++
 rtl/param_shift_register.sv | 100 ++++++++++
 tb/tb_param_shift_register.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/psr_pkg.sv
// Shared types for the parametrised shift register: operation encodings,
// sequencer states and the shift-mode classifier.
package psr_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHR  = 3'b010,
        MODE_SHL  = 3'b011,
        MODE_ROR  = 3'b100,
        MODE_ROL  = 3'b101,
        MODE_ASR  = 3'b110,
        MODE_CLR  = 3'b111
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } seq_state_e;

    function automatic logic is_shift_mode(input mode_e m);
        return (m == MODE_SHR) || (m == MODE_SHL) || (m == MODE_ROR) ||
               (m == MODE_ROL) || (m == MODE_ASR);
    endfunction

endpackage

// File: rtl/psr_next_value.sv
// Combinational next-value datapath shared by direct and sequenced operation.
module psr_next_value
    import psr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_cur,
    input  mode_e            mode,
    input  logic [WIDTH-1:0] d,
    input  logic             shr_in,
    input  logic             shl_in,
    output logic [WIDTH-1:0] q_next
);

    always_comb begin
        q_next = q_cur;
        case (mode)
            MODE_HOLD: q_next = q_cur;
            MODE_LOAD: q_next = d;
            MODE_SHR:  q_next = {shr_in, q_cur[WIDTH-1:1]};
            MODE_SHL:  q_next = {q_cur[WIDTH-2:0], shl_in};
            MODE_ROR:  q_next = {q_cur[0], q_cur[WIDTH-1:1]};
            MODE_ROL:  q_next = {q_cur[WIDTH-2:0], q_cur[WIDTH-1]};
            MODE_ASR:  q_next = {q_cur[WIDTH-1], q_cur[WIDTH-1:1]};
            MODE_CLR:  q_next = '0;
            default:   q_next = q_cur;
        endcase
    end

endmodule

// File: rtl/param_shift_register.sv
// Universal WIDTH-bit shift register with a multi-step shift sequencer
// (IDLE -> RUN -> DONE) and busy/done handshake.
module param_shift_register
    import psr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             shr_in,
    input  logic             shl_in,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    seq_state_e       state_q, state_d;
    mode_e            seq_mode_q, seq_mode_d;
    mode_e            mode_in, op_mode;
    logic [WIDTH-1:0] q_next;

    assign mode_in = mode_e'(mode);
    // While running, the latched mode drives the datapath and live mode is ignored.
    assign op_mode = (state_q == ST_RUN) ? seq_mode_q : mode_in;

    psr_next_value #(.WIDTH(WIDTH)) u_next (
        .q_cur  (q_q),
        .mode   (op_mode),
        .d      (d),
        .shr_in (shr_in),
        .shl_in (shl_in),
        .q_next (q_next)
    );

    always_comb begin
        q_d        = q_q;
        rem_d      = rem_q;
        state_d    = state_q;
        seq_mode_d = seq_mode_q;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    if (start && is_shift_mode(mode_in)) begin
                        if (count == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            seq_mode_d = mode_in;
                            rem_d      = count;
                            state_d    = ST_RUN;
                        end
                    end else begin
                        q_d = q_next;
                    end
                end
            end
            ST_RUN: begin
                if (en) begin
                    q_d   = q_next;
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q        <= '0;
            rem_q      <= '0;
            state_q    <= ST_IDLE;
            seq_mode_q <= MODE_HOLD;
        end else begin
            q_q        <= q_d;
            rem_q      <= rem_d;
            state_q    <= state_d;
            seq_mode_q <= seq_mode_d;
        end
    end

    assign q      = q_q;
    assign sout_r = q_q[0];
    assign sout_l = q_q[WIDTH-1];
    assign busy   = (state_q == ST_RUN);
    assign done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_param_shift_register.sv
// Directed-vector bench for param_shift_register at WIDTH=8.
module tb_param_shift_register;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHR  = 3'b010;
    localparam logic [2:0] M_SHL  = 3'b011;
    localparam logic [2:0] M_ROR  = 3'b100;
    localparam logic [2:0] M_ROL  = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    logic             clk = 1'b0;
    logic             reset, en, shr_in, shl_in, start;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] q;
    logic             sout_r, sout_l, busy, done;

    int n_checks = 0;
    int n_fail   = 0;
    int busy_cycles;
    int waited;

    always #5 clk = ~clk;

    param_shift_register #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .mode   (mode),
        .d      (d),
        .shr_in (shr_in),
        .shl_in (shl_in),
        .start  (start),
        .count  (count),
        .q      (q),
        .sout_r (sout_r),
        .sout_l (sout_l),
        .busy   (busy),
        .done   (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [2:0] m, input logic [WIDTH-1:0] dv);
        mode = m;
        d    = dv;
        tick();
    endtask

    task automatic check_state(input string tag, input logic [WIDTH-1:0] eq,
                               input logic eb, input logic ed);
        check_eq({tag, "_q"}, 32'(q), 32'(eq));
        check_eq({tag, "_busy"}, 32'(busy), 32'(eb));
        check_eq({tag, "_done"}, 32'(done), 32'(ed));
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; mode = M_HOLD; d = '0;
        shr_in = 1'b0; shl_in = 1'b0; start = 1'b0; count = '0;
        tick(); tick();
        check_state("reset", 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        en    = 1'b1;

        // Direct operations
        op(M_LOAD, 8'hA5);
        check_eq("load", 32'(q), 32'h A5);
        check_eq("sout_r", 32'(sout_r), 32'd1);
        check_eq("sout_l", 32'(sout_l), 32'd1);
        shr_in = 1'b1;
        op(M_SHR, 8'h00);
        check_eq("shr", 32'(q), 32'hD2);
        shl_in = 1'b0; shr_in = 1'b0;
        op(M_SHL, 8'h00);
        check_eq("shl", 32'(q), 32'hA4);
        check_eq("sout_r_lo", 32'(sout_r), 32'd0);
        op(M_LOAD, 8'h81);
        op(M_ROR, 8'h00);
        check_eq("ror", 32'(q), 32'hC0);
        op(M_LOAD, 8'h81);
        op(M_ROL, 8'h00);
        check_eq("rol", 32'(q), 32'h03);
        op(M_LOAD, 8'h90);
        op(M_ASR, 8'h00);
        check_eq("asr", 32'(q), 32'hC8);
        op(M_CLR, 8'h00);
        check_eq("clr", 32'(q), 32'h00);
        en = 1'b0;
        op(M_LOAD, 8'h55);
        check_eq("en_low_hold", 32'(q), 32'h00);
        en = 1'b1;
        shl_in = 1'b1;
        start  = 1'b1; count = 4'd2;
        op(M_LOAD, 8'h3C);
        check_state("start_nonshift", 8'h3C, 1'b0, 1'b0);
        start = 1'b0; shl_in = 1'b0;

        // Sequenced ROL x3, mode/d wiggled during RUN
        op(M_LOAD, 8'h01);
        start = 1'b1; count = 4'd3;
        op(M_ROL, 8'h00);
        check_state("seq_rol_start", 8'h01, 1'b1, 1'b0);
        start = 1'b0;
        op(M_LOAD, 8'hFF);
        check_state("seq_rol_1", 8'h02, 1'b1, 1'b0);
        op(M_CLR, 8'hFF);
        check_state("seq_rol_2", 8'h04, 1'b1, 1'b0);
        op(M_SHR, 8'hFF);
        check_state("seq_rol_3", 8'h08, 1'b0, 1'b1);
        op(M_HOLD, 8'h00);
        check_state("seq_rol_idle", 8'h08, 1'b0, 1'b0);

        // count = 0 goes straight to DONE
        start = 1'b1; count = 4'd0;
        op(M_SHR, 8'h00);
        check_state("cnt0_done", 8'h08, 1'b0, 1'b1);
        start = 1'b0;
        op(M_HOLD, 8'h00);
        check_state("cnt0_idle", 8'h08, 1'b0, 1'b0);

        // Sequenced SHR x4 with a 2-cycle pause
        op(M_LOAD, 8'hFF);
        shr_in = 1'b0;
        busy_cycles = 0;
        start = 1'b1; count = 4'd4;
        op(M_SHR, 8'h00);
        start = 1'b0;
        busy_cycles += int'(busy);
        check_state("pause_start", 8'hFF, 1'b1, 1'b0);
        op(M_HOLD, 8'h00); busy_cycles += int'(busy);
        check_state("pause_s1", 8'h7F, 1'b1, 1'b0);
        op(M_HOLD, 8'h00); busy_cycles += int'(busy);
        check_state("pause_s2", 8'h3F, 1'b1, 1'b0);
        en = 1'b0;
        op(M_HOLD, 8'h00); busy_cycles += int'(busy);
        check_state("pause_p1", 8'h3F, 1'b1, 1'b0);
        op(M_HOLD, 8'h00); busy_cycles += int'(busy);
        check_state("pause_p2", 8'h3F, 1'b1, 1'b0);
        en = 1'b1;
        op(M_HOLD, 8'h00); busy_cycles += int'(busy);
        check_state("pause_s3", 8'h1F, 1'b1, 1'b0);
        op(M_HOLD, 8'h00); busy_cycles += int'(busy);
        check_state("pause_s4", 8'h0F, 1'b0, 1'b1);
        check_eq("pause_busy_total", 32'(busy_cycles), 32'd6);
        en = 1'b0;
        op(M_HOLD, 8'h00);
        check_state("done_exit_en0", 8'h0F, 1'b0, 1'b0);
        en = 1'b1;

        // count > WIDTH: ROL by 9 wraps to ROL by 1
        op(M_LOAD, 8'h81);
        start = 1'b1; count = 4'd9;
        op(M_ROL, 8'h00);
        start = 1'b0;
        waited = 0;
        while (!done && waited < 20) begin
            op(M_HOLD, 8'h00);
            waited++;
        end
        check_eq("wrap_waited", 32'(waited), 32'd9);
        check_eq("wrap_q", 32'(q), 32'h03);
        op(M_HOLD, 8'h00);

        // Reset mid-RUN aborts without a done pulse
        op(M_LOAD, 8'h0F);
        start = 1'b1; count = 4'd5;
        op(M_ROR, 8'h00);
        start = 1'b0;
        op(M_HOLD, 8'h00);
        check_state("abort_run", 8'h87, 1'b1, 1'b0);
        reset = 1'b1;
        op(M_HOLD, 8'h00);
        check_state("abort_reset", 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            op(M_HOLD, 8'h00);
            check_state("abort_after", 8'h00, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
